// File: rtl/fifo16b_pkg.sv
// Shared sizing constants for the fifo16b buffer and its 32x16 RAM.
package fifo16b_pkg;

  localparam int FIFO16B_DEPTH = 32;
  localparam int FIFO16B_AW    = 5;
  localparam int FIFO16B_DW    = 16;
  // Pointers carry one extra wrap bit above the RAM address.
  localparam int FIFO16B_PW    = FIFO16B_AW + 1;

endpackage

// File: rtl/fifo16b_ram16b.sv
// 32x16 dual-port RAM primitive: synchronous write, registered read address.
module ram16b
  import fifo16b_pkg::*;
(
  input  logic                  wclk_i,
  input  logic                  wen_i,
  input  logic [FIFO16B_AW-1:0] waddr_i,
  input  logic [FIFO16B_DW-1:0] wdata_i,
  input  logic                  rclk_i,
  input  logic [FIFO16B_AW-1:0] raddr_i,
  output logic [FIFO16B_DW-1:0] rdata_o
);

  logic [FIFO16B_DW-1:0] mem_q [FIFO16B_DEPTH];
  logic [FIFO16B_AW-1:0] raddr_q;

  always_ff @(posedge wclk_i) begin
    if (wen_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge rclk_i) begin
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/fifo16b.sv
// 32x16 first-word-fall-through FIFO built around ram16b.
// Define FIFO16B_ERR_EN to add sticky overflow/underflow flags with clr_err_i.
module fifo16b
  import fifo16b_pkg::*;
#(
  parameter int AFULL_LEVEL = 28
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [FIFO16B_DW-1:0] wdata_i,
  input  logic                  pop_i,
`ifdef FIFO16B_ERR_EN
  input  logic                  clr_err_i,
  output logic                  ovf_o,
  output logic                  udf_o,
`endif
  output logic                  full_o,
  output logic                  afull_o,
  output logic [FIFO16B_DW-1:0] rdata_o,
  output logic                  valid_o,
  output logic [5:0]            level_o
);

  localparam logic [FIFO16B_PW:0] AfullLvl = (FIFO16B_PW + 1)'(AFULL_LEVEL);
  localparam logic [FIFO16B_PW-1:0] DepthLvl = FIFO16B_PW'(FIFO16B_DEPTH);

  logic [FIFO16B_PW-1:0] wptr_q, wptr_d;
  logic [FIFO16B_PW-1:0] rptr_q, rptr_d;
  logic [FIFO16B_PW-1:0] wvis_q;
  logic [FIFO16B_PW-1:0] level;
  logic                  push_acc;
  logic                  pop_acc;

  assign level    = wptr_q - rptr_q;
  assign full_o   = (level == DepthLvl);
  assign afull_o  = ({1'b0, level} >= AfullLvl);
  assign level_o  = level;
  // Only words whose write landed at least one edge ago are exposed,
  // so the RAM never reads an address in the cycle it is written.
  assign valid_o  = (wvis_q != rptr_q);

  assign push_acc = push_i & ~full_o;
  assign pop_acc  = pop_i & valid_o;

  always_comb begin
    wptr_d = wptr_q + {{(FIFO16B_PW-1){1'b0}}, push_acc};
    rptr_d = rptr_q + {{(FIFO16B_PW-1){1'b0}}, pop_acc};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      wvis_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wvis_q <= wptr_q;
    end
  end

  // Read address looks one pop ahead so the next head is ready right after a pop.
  ram16b u_ram (
    .wclk_i  (clk_i),
    .wen_i   (push_acc),
    .waddr_i (wptr_q[FIFO16B_AW-1:0]),
    .wdata_i (wdata_i),
    .rclk_i  (clk_i),
    .raddr_i (rptr_d[FIFO16B_AW-1:0]),
    .rdata_o (rdata_o)
  );

`ifdef FIFO16B_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = (ovf_q & ~clr_err_i) | (push_i & full_o);
    udf_d = (udf_q & ~clr_err_i) | (pop_i & ~valid_o);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_fifo16b.sv
// Self-checking bench for fifo16b against a queue-based reference model.
// Build with FIFO16B_ERR_EN defined to also exercise the sticky error flags.
module tb_fifo16b;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        push_i;
  logic [15:0] wdata_i;
  logic        pop_i;
  logic        full_o;
  logic        afull_o;
  logic [15:0] rdata_o;
  logic        valid_o;
  logic [5:0]  level_o;
`ifdef FIFO16B_ERR_EN
  logic        clr_err_i;
  logic        ovf_o;
  logic        udf_o;
  bit          ovfM, udfM;
`endif

  typedef struct {
    logic [15:0] data;
    int          edgeNo;
  } entry_t;

  entry_t q[$];
  int     edgeCnt = 0;
  int     errors  = 0;
  int     checks  = 0;

  always #5 clk_i = ~clk_i;

  fifo16b #(.AFULL_LEVEL(28)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_i    (push_i),
    .wdata_i   (wdata_i),
    .pop_i     (pop_i),
`ifdef FIFO16B_ERR_EN
    .clr_err_i (clr_err_i),
    .ovf_o     (ovf_o),
    .udf_o     (udf_o),
`endif
    .full_o    (full_o),
    .afull_o   (afull_o),
    .rdata_o   (rdata_o),
    .valid_o   (valid_o),
    .level_o   (level_o)
  );

  // A word is visible once an edge has passed after the edge that wrote it.
  function automatic bit modelValid();
    return (q.size() > 0) && (q[0].edgeNo <= edgeCnt - 1);
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edgeCnt);
    end
  endtask

  task automatic checkOutput();
    checkEq("valid", 32'(valid_o), 32'(modelValid()));
    checkEq("level", 32'(level_o), 32'(q.size()));
    checkEq("full",  32'(full_o),  32'(q.size() == 32));
    checkEq("afull", 32'(afull_o), 32'(q.size() >= 28));
    if (modelValid()) checkEq("rdata", 32'(rdata_o), 32'(q[0].data));
`ifdef FIFO16B_ERR_EN
    checkEq("ovf", 32'(ovf_o), 32'(ovfM));
    checkEq("udf", 32'(udf_o), 32'(udfM));
`endif
  endtask

  task automatic applyStimulus(input bit p, input logic [15:0] d, input bit pp);
    bit fullM, validM;
    push_i  = p;
    wdata_i = d;
    pop_i   = pp;
    fullM   = (q.size() == 32);
    validM  = modelValid();
`ifdef FIFO16B_ERR_EN
    ovfM = (p && fullM) ? 1'b1 : (clr_err_i ? 1'b0 : ovfM);
    udfM = (pp && !validM) ? 1'b1 : (clr_err_i ? 1'b0 : udfM);
`endif
    @(posedge clk_i);
    edgeCnt++;
    if (pp && validM) void'(q.pop_front());
    if (p && !fullM) q.push_back('{data: d, edgeNo: edgeCnt});
    #1;
    checkOutput();
  endtask

  task automatic applyReset();
    reset_i = 1'b1;
    push_i  = 1'b0;
    pop_i   = 1'b0;
    #1;
    q.delete();
`ifdef FIFO16B_ERR_EN
    ovfM = 1'b0;
    udfM = 1'b0;
`endif
    checkOutput();
    @(posedge clk_i);
    edgeCnt++;
    #1;
    reset_i = 1'b0;
    checkOutput();
  endtask

  initial begin
    push_i  = 1'b0;
    pop_i   = 1'b0;
    wdata_i = '0;
`ifdef FIFO16B_ERR_EN
    clr_err_i = 1'b0;
    ovfM = 1'b0;
    udfM = 1'b0;
`endif
    applyReset();
    repeat (2) applyStimulus(0, 16'h0, 0);

    $display("[TB] single word latency");
    applyStimulus(1, 16'hA5A5, 0);
    checkEq("single_hidden", 32'(valid_o), 32'(0));
    applyStimulus(0, 16'h0, 0);
    checkEq("single_visible", 32'(rdata_o), 32'h0000A5A5);
    applyStimulus(0, 16'h0, 1);
    checkEq("single_drained", 32'(level_o), 32'(0));

    $display("[TB] fill to full, drop extra push, drain in order");
    for (int i = 0; i < 32; i++) applyStimulus(1, 16'(i), 0);
    checkEq("fill_full", 32'(full_o), 32'(1));
    applyStimulus(1, 16'hDEAD, 0);
    checkEq("fill_level", 32'(level_o), 32'(32));
    for (int i = 0; i < 32; i++) begin
      checkEq("drain_word", 32'(rdata_o), 32'(i));
      applyStimulus(0, 16'h0, 1);
    end
    checkEq("drain_empty", 32'(valid_o), 32'(0));

    $display("[TB] steady level 16 with simultaneous push/pop");
    for (int i = 0; i < 16; i++) applyStimulus(1, 16'($urandom), 0);
    applyStimulus(0, 16'h0, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1, 16'($urandom), 1);
      checkEq("steady_level", 32'(level_o), 32'(16));
    end

    $display("[TB] push/pop on full");
    for (int i = 0; i < 16; i++) applyStimulus(1, 16'($urandom), 0);
    applyStimulus(0, 16'h0, 0);
    applyStimulus(1, 16'hBEEF, 1);
    checkEq("full_pushpop", 32'(level_o), 32'(31));

    $display("[TB] asynchronous reset at level 10");
    while (q.size() > 0) applyStimulus(0, 16'h0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1, 16'($urandom), 0);
    #2;
    applyReset();
    applyStimulus(1, 16'h1234, 0);
    applyStimulus(0, 16'h0, 0);
    checkEq("post_reset", 32'(rdata_o), 32'h00001234);
    applyStimulus(0, 16'h0, 1);

`ifdef FIFO16B_ERR_EN
    $display("[TB] sticky error flags");
    repeat (2) applyStimulus(0, 16'h0, 1);
    checkEq("udf_set", 32'(udf_o), 32'(1));
    for (int i = 0; i < 33; i++) applyStimulus(1, 16'($urandom), 0);
    checkEq("ovf_set", 32'(ovf_o), 32'(1));
    clr_err_i = 1'b1;
    applyStimulus(1, 16'h0, 0);
    checkEq("set_wins", 32'(ovf_o), 32'(1));
    applyStimulus(0, 16'h0, 0);
    clr_err_i = 1'b0;
    checkEq("ovf_clr", 32'(ovf_o), 32'(0));
    checkEq("udf_clr", 32'(udf_o), 32'(0));
    applyStimulus(0, 16'h0, 0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i < 200) ? 70 : ((i < 400) ? 30 : 50);
      applyStimulus($urandom_range(0, 99) < bias, 16'($urandom),
                    $urandom_range(0, 99) >= bias);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo16b.md
Name: fifo16b

Overview:
- 32-entry x 16-bit synchronous FIFO; the read/write client of the 32x16 dual-port RAM primitive (registered read address).
- Drives that RAM's write and read ports, handles its one-cycle read latency, and presents a first-word-fall-through (FWFT) valid/pop interface.
- Used as the buffer between CPU-side producers and slower consumers (e.g. UART/SPI data paths) in the KCP53K-based system.

Parameters:
- AFULL_LEVEL, 28, level (0..32) at or above which afull_o asserts.

Ports:
- clk_i  input  1  single clock; drives both RAM wclk and rclk.
- reset_i  input  1  asynchronous, active-high reset.
- push_i  input  1  write request.
- wdata_i  input  16  write data, sampled with push_i.
- full_o  output  1  level == 32.
- afull_o  output  1  level >= AFULL_LEVEL.
- pop_i  input  1  consume head word.
- rdata_o  output  16  head word; meaningful only while valid_o.
- valid_o  output  1  head word visible.
- level_o  output  6  entries held, 0..32.

Behaviour:
- Pointers:
  - wptr, rptr: 6 bits each; low 5 bits address the RAM, the MSB is the wrap bit.
  - level = wptr - rptr (mod 64).
  - wptr_vis: wptr delayed one clock (write-visibility pointer).
- Accept rules:
  - push_acc = push_i & ~full_o. A push while full is dropped; state is unchanged.
  - pop_acc = pop_i & valid_o. A pop while not valid is ignored.
  - Push and pop in the same cycle are both accepted when the rules above allow. A push while full is rejected even if a pop is accepted in the same cycle.
- RAM hookup:
  - waddr = wptr[4:0], wdata = wdata_i, wen = push_acc.
  - raddr = rptr_next[4:0], where rptr_next = rptr + pop_acc.
  - rdata_o = RAM rdata, which therefore always shows memory[rptr].
- valid_o = (wptr_vis != rptr), registered via pointers.
  - A push sampled at edge N becomes visible after edge N+1 (2-edge write-to-read latency).
  - This avoids same-cycle RAM read/write collision on iCE40.
- Pop latency: pop_acc at edge N; the next word is on rdata_o after edge N. There is no bubble for back-to-back pops when words are visible.
- level_o, full_o, afull_o are derived from the registered wptr/rptr and update after the accepting edge.
- Wrap-around: pointers wrap from 63 to 0. Full is level == 32 (low bits equal, MSBs differ); empty is wptr == rptr.
- Reset values (asynchronous, any time, including mid-transfer):
  - wptr = rptr = wptr_vis = 0.
  - valid_o = 0, full_o = 0, afull_o = 0 (when AFULL_LEVEL > 0), level_o = 0.
  - RAM contents are don't-care. rdata_o is don't-care while valid_o = 0.

Optional Feature:
- Macro: FIFO16B_ERR_EN.
- Defined:
  - Adds outputs ovf_o and udf_o, sticky.
  - ovf_o is set by push_i & full_o; udf_o is set by pop_i & ~valid_o.
  - Both are cleared only by reset_i or by clr_err_i (input, 1 bit, synchronous). If set and clear occur in the same cycle, set wins.
- Undefined: none of these ports exist; rejected push/pop are silently dropped.

Decomposition:
- Shared package constants: FIFO16B_DEPTH = 32, FIFO16B_AW = 5, FIFO16B_DW = 16.
- Sub-module: the existing ram16b storage is instantiated, not reimplemented.
- All control (pointers, visibility, flags) lives in fifo16b itself; no further sub-module.

Test Plan:
- Reset, then idle -> valid_o = 0, level_o = 0, full_o = 0, afull_o = 0.
- Single push 16'hA5A5 at edge N -> valid_o = 0 after edge N, valid_o = 1 with rdata_o = 16'hA5A5 after edge N+1; pop -> valid_o = 0, level_o = 0.
- Push 0..31 back-to-back -> full_o = 1 and level_o = 32 after the 32nd edge, afull_o = 1 from level 28. A 33rd push of 16'hDEAD is dropped. Popping 32 consecutive cycles returns 0..31 in order with no gaps.
- Fill to 16, then simultaneous push/pop for 100 cycles (crossing pointer wrap) -> level_o constant at 16; data order preserved.
- Full FIFO with push_i = pop_i = 1 in one cycle -> pop accepted, push rejected, level_o = 31.
- Assert reset_i mid-stream at level 10 -> all outputs return to reset values immediately. The next push of 16'h1234 reads back as 16'h1234. With FIFO16B_ERR_EN: pop on empty sets udf_o, push on full sets ovf_o, clr_err_i clears both.
